// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, decode read ports and debug taps.
// The pipeline drives through the master modport and the register file is the slave.
interface wb_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              MemToReg;
    logic              RegWrite;
    logic [DATA_W-1:0] MemoryReadData;
    logic [DATA_W-1:0] AluOut;
    logic [ADDR_W-1:0] RegDst;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WriteData;
    logic              WbValid;
    logic [CNT_W-1:0]  RetireCount;

    modport master (
        output MemToReg, RegWrite, MemoryReadData, AluOut, RegDst, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, WriteData, WbValid, RetireCount
    );

    modport slave (
        input  MemToReg, RegWrite, MemoryReadData, AluOut, RegDst, ReadReg1, ReadReg2,
        output ReadData1, ReadData2, WriteData, WbValid, RetireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result, commits it to an 8-entry register file with r0
// hardwired to zero, serves two bypassed read ports and counts retired writes.
module wb_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  retire_q;
    logic [CNT_W-1:0]  retire_d;
    logic [DATA_W-1:0] write_data_s;
    logic              wb_valid_s;
    logic [DATA_W-1:0] read_data1_s;
    logic [DATA_W-1:0] read_data2_s;

    // Entry 0 is never written, but the read path masks it anyway so r0 can never bypass.
    function automatic logic [DATA_W-1:0] port_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wb_valid,
        input logic [ADDR_W-1:0] dst,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] value;
        if (addr == {ADDR_W{1'b0}}) begin
            value = {DATA_W{1'b0}};
        end else if (wb_valid && (addr == dst)) begin
            value = wdata;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Result select, commit qualifier, counter next state and both read ports.
    always_comb begin
        write_data_s = bus.AluOut;
        wb_valid_s   = 1'b0;
        retire_d     = retire_q;
        if (bus.MemToReg) begin
            write_data_s = bus.MemoryReadData;
        end else begin
            write_data_s = bus.AluOut;
        end
        if (bus.RegWrite && (bus.RegDst != {ADDR_W{1'b0}})) begin
            wb_valid_s = 1'b1;
            retire_d   = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wb_valid_s = 1'b0;
            retire_d   = retire_q;
        end
        read_data1_s = port_read(bus.ReadReg1, regs_q[bus.ReadReg1], wb_valid_s, bus.RegDst, write_data_s);
        read_data2_s = port_read(bus.ReadReg2, regs_q[bus.ReadReg2], wb_valid_s, bus.RegDst, write_data_s);
    end

    // Register storage and retirement counter; reset clears both at once, mid-cycle included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            retire_q <= {CNT_W{1'b0}};
        end else begin
            if (wb_valid_s) begin
                regs_q[bus.RegDst] <= write_data_s;
            end
            retire_q <= retire_d;
        end
    end

    assign bus.WriteData   = write_data_s;
    assign bus.WbValid     = wb_valid_s;
    assign bus.ReadData1   = read_data1_s;
    assign bus.ReadData2   = read_data2_s;
    assign bus.RetireCount = retire_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, random traffic against an
// array model, counter wrap and asynchronous reset sequences.
module tb_wb_regfile;
    logic clk;
    logic rst;

    wb_regfile_if #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) bus ();

    wb_regfile #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    int m_regs [8];
    int m_cnt;

    typedef struct {
        logic       mtr;
        logic       rw;
        logic [7:0] mrd;
        logic [7:0] alu;
        logic [2:0] dst;
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic [7:0] e_wd;
        logic       e_wbv;
        logic [7:0] e_rd1;
        logic [7:0] e_rd2;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic mtr, input logic rw, input logic [7:0] mrd, input logic [7:0] alu,
                         input logic [2:0] dst, input logic [2:0] rr1, input logic [2:0] rr2);
        bus.MemToReg       = mtr;
        bus.RegWrite       = rw;
        bus.MemoryReadData = mrd;
        bus.AluOut         = alu;
        bus.RegDst         = dst;
        bus.ReadReg1       = rr1;
        bus.ReadReg2       = rr2;
    endtask

    function automatic int m_wd();
        return bus.MemToReg ? int'(bus.MemoryReadData) : int'(bus.AluOut);
    endfunction

    function automatic bit m_wbv();
        return bus.RegWrite && (bus.RegDst != 3'd0);
    endfunction

    function automatic int m_read(input logic [2:0] a);
        if (a == 3'd0) return 0;
        if (m_wbv() && a == bus.RegDst) return m_wd();
        return m_regs[a];
    endfunction

    // One rising edge; the model commits only when out of reset.
    task automatic step();
        int  wd;
        bit  wbv;
        wd  = m_wd();
        wbv = m_wbv();
        @(posedge clk);
        if (rst && wbv) begin
            m_regs[bus.RegDst] = wd;
            m_cnt = (m_cnt + 1) % 65536;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_cnt = 0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'hA7, 8'h11, 3'd2, 3'd2, 3'd3, 8'hA7, 1'b1, 8'hA7, 8'h55, 16'd1};
        vecs[1] = '{1'b0, 1'b1, 8'hA7, 8'h11, 3'd4, 3'd2, 3'd4, 8'h11, 1'b1, 8'hA7, 8'h11, 16'd2};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h20, 3'd5, 3'd4, 3'd5, 8'h20, 1'b1, 8'h11, 8'h20, 16'd3};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h9C, 3'd5, 3'd5, 3'd5, 8'h9C, 1'b1, 8'h9C, 8'h9C, 16'd4};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 3'd0, 3'd0, 3'd5, 8'hFF, 1'b0, 8'h00, 8'h9C, 16'd5};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h33, 3'd6, 3'd6, 3'd5, 8'h33, 1'b0, 8'h00, 8'h9C, 16'd5};
        vecs[6] = '{1'b1, 1'b0, 8'hC3, 8'h00, 3'd3, 3'd6, 3'd3, 8'hC3, 1'b0, 8'h00, 8'h55, 16'd5};

        model_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h00, 8'h55, 3'd3, 3'd1, 3'd7);
        #2 rst = 1'b0;

        // Held in reset with a live write request: nothing commits.
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("reset_rd1", bus.ReadData1, 32'h0);
            chk("reset_rd2", bus.ReadData2, 32'h0);
            chk("reset_cnt", bus.RetireCount, 32'h0);
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd3, 3'd0);
        #1;
        chk("first_commit_r3", bus.ReadData1, 32'h55);
        chk("first_commit_cnt", bus.RetireCount, 32'h1);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].mtr, vecs[i].rw, vecs[i].mrd, vecs[i].alu, vecs[i].dst, vecs[i].rr1, vecs[i].rr2);
            #1;
            chk($sformatf("vec%0d_wd", i),  bus.WriteData,   {24'h0, vecs[i].e_wd});
            chk($sformatf("vec%0d_wbv", i), bus.WbValid,     {31'h0, vecs[i].e_wbv});
            chk($sformatf("vec%0d_rd1", i), bus.ReadData1,   {24'h0, vecs[i].e_rd1});
            chk($sformatf("vec%0d_rd2", i), bus.ReadData2,   {24'h0, vecs[i].e_rd2});
            chk($sformatf("vec%0d_cnt", i), bus.RetireCount, {16'h0, vecs[i].e_cnt});
            step();
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd5, 3'd2);
        #1;
        chk("stored_r5", bus.ReadData1, 32'h9C);
        chk("stored_r2", bus.ReadData2, 32'hA7);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd4, 3'd6);
        #1;
        chk("stored_r4", bus.ReadData1, 32'h11);
        chk("unwritten_r6", bus.ReadData2, 32'h0);
        chk("table_end_cnt", bus.RetireCount, 32'd5);

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] d;
            @(negedge clk);
            d = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), d, d, d);
            else
                drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), d,
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            #1;
            chk("rand_wd",  bus.WriteData,   32'(m_wd()));
            chk("rand_wbv", bus.WbValid,     32'(m_wbv()));
            chk("rand_rd1", bus.ReadData1,   32'(m_read(bus.ReadReg1)));
            chk("rand_rd2", bus.ReadData2,   32'(m_read(bus.ReadReg2)));
            chk("rand_cnt", bus.RetireCount, 32'(m_cnt));
            step();
        end

        // Advance the counter to 0xFFFE, then cross the wrap.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h00, 8'h5A, 3'd1, 3'd1, 3'd2);
        while (m_cnt != 16'hFFFE) step();
        @(negedge clk);
        chk("cnt_fffe", bus.RetireCount, 32'hFFFE);
        step();
        @(negedge clk);
        chk("cnt_ffff", bus.RetireCount, 32'hFFFF);
        step();
        @(negedge clk);
        chk("cnt_wrap", bus.RetireCount, 32'h0);

        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd1, 3'd2);
        #1;
        chk("pre_reset_r1", bus.ReadData1, 32'h5A);
        chk("pre_reset_r2", bus.ReadData2, 32'(m_regs[2]));
        step();
        @(negedge clk);
        chk("pre_reset_cnt", bus.RetireCount, 32'h0);
        step();
        step();
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h00, 8'h44, 3'd1, 3'd1, 3'd2);
        step();
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd1, 3'd2);
        #1;
        chk("cnt_before_async", bus.RetireCount, 32'h1);
        chk("r1_before_async", bus.ReadData1, 32'h44);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("async_cnt", bus.RetireCount, 32'h0);
        chk("async_r1", bus.ReadData1, 32'h0);
        chk("async_r2", bus.ReadData2, 32'h0);

        // Write pending while reset is held is lost.
        drive(1'b0, 1'b1, 8'h00, 8'h77, 3'd7, 3'd1, 3'd2);
        step();
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd7, 3'd3);
        rst = 1'b1;
        #1;
        chk("lost_write_r7", bus.ReadData1, 32'h0);
        chk("lost_write_r3", bus.ReadData2, 32'h0);
        chk("lost_write_cnt", bus.RetireCount, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and register file for the 8-bit pipelined MIPS core: the consumer of the MEM/WB pipeline register outputs. Selects the write-back value (memory read data or ALU result), commits it to an 8-entry register file on the clock edge, and serves the two decode-stage read ports. Read ports include write-through bypass. A forwarding tap and a retirement counter feed the hazard unit and the debug logic.

## Interface
Parameters:
- DATA_W, 8, register and data width
- ADDR_W, 3, register address width; depth = 2^ADDR_W = 8
- CNT_W, 16, retirement counter width

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-low reset; one clock domain only
- MemToReg  in  1  1 selects MemoryReadData, 0 selects AluOut (from MEM/WB)
- RegWrite  in  1  write enable (from MEM/WB)
- MemoryReadData  in  DATA_W  load data (from MEM/WB)
- AluOut  in  DATA_W  ALU result (from MEM/WB)
- RegDst  in  ADDR_W  destination register (from MEM/WB)
- ReadReg1  in  ADDR_W  decode read address, port 1
- ReadReg2  in  ADDR_W  decode read address, port 2
- ReadData1  out  DATA_W  read data, port 1
- ReadData2  out  DATA_W  read data, port 2
- WriteData  out  DATA_W  selected write-back value (forwarding tap)
- WbValid  out  1  a committing write is present this cycle
- RetireCount  out  CNT_W  number of committed register writes

## Operation
- WriteData = MemToReg ? MemoryReadData : AluOut. This path is combinational at all times, including when RegWrite = 0.
- WbValid = RegWrite && (RegDst != 0). This path is combinational.
- Register r0 is hardwired to 0:
  - Writes to r0 are discarded.
  - Reads of r0 return 0.
  - r0 is never bypassed.
  - Writes to r0 do not count as retirements.
- Commit: on a rising clk edge with WbValid = 1, regs[RegDst] <= WriteData. No other register changes.
- Read ports are combinational with write-through bypass. For port i:
  - If ReadRegi == 0: ReadDatai = 0.
  - Else if WbValid and ReadRegi == RegDst: ReadDatai = WriteData.
  - Otherwise: ReadDatai = regs[ReadRegi].
- Both ports may address the same register. Both then return identical data, including bypass.
- RetireCount increments by 1 on every rising edge where WbValid = 1. It wraps modulo 2^CNT_W (0xFFFF -> 0x0000) with no saturation and no flag.

## Timing
- Reset (rst = 0) is asynchronous and takes effect immediately, independent of clk:
  - regs[1..7] = 0.
  - RetireCount = 0.
  - ReadData1/2 reflect the reset contents, i.e. 0 unless bypassing.
- While rst = 0, no commit occurs and the counter holds at 0, regardless of RegWrite.
- Deassertion of rst is synchronous-released by the system reset block. The first commit can occur on the first rising edge at which rst = 1.
- Reset mid-write: if rst falls in the same cycle as a pending write, the write is lost and the target register reads 0.
- Write latency: the value is visible on the read ports in the same cycle via bypass. It is visible from storage starting the cycle after the edge.
- Read latency: zero cycles (combinational). Decode samples ReadData1/2 into ID/EX on the same edge as the commit. This gives write-first-half / read-second-half semantics with no extra stall.
- Outputs change only in response to inputs or a clock edge. There are no internal states beyond the storage and the counter.
- Simultaneous events: a commit and a read of the same register in the same cycle return the new value. A commit to r0 together with a read of r0 returns 0.

## Test plan
- Reset: hold rst = 0, toggle clk with RegWrite = 1, RegDst = 3, AluOut = 0x55.
  - Required: all reads return 0x00 and RetireCount = 0.
  - Release rst, one edge. Required: r3 = 0x55 and RetireCount = 1.
- Source select: RegWrite = 1, RegDst = 2, AluOut = 0x11, MemoryReadData = 0xA7.
  - With MemToReg = 1, after the edge: ReadReg1 = 2 returns 0xA7.
  - Repeat with MemToReg = 0 and RegDst = 4. Required: r4 = 0x11.
- Bypass: r5 = 0x20 in storage. Drive RegWrite = 1, RegDst = 5, AluOut = 0x9C, ReadReg1 = ReadReg2 = 5 before the edge.
  - Required: both ports return 0x9C pre-edge, and storage holds 0x9C post-edge.
- r0 protection: RegWrite = 1, RegDst = 0, AluOut = 0xFF.
  - Required: WbValid = 0, ReadReg1 = 0 returns 0x00, and RetireCount is unchanged.
- Disabled write: RegWrite = 0, RegDst = 6, AluOut = 0x33.
  - Required: r6 is unchanged, no bypass, WriteData = 0x33, and WbValid = 0.
- Counter wrap and async reset: preload the counter to 0xFFFE via 2 commits after forcing, or run 65534 commits. Two more commits give 0xFFFF, then 0x0000.
  - Then pull rst low mid-cycle between edges. Required: RetireCount and regs clear immediately, before the next clk edge.
